// File: rtl/axi_stream_header_arbiter.sv
// +--------------------------------------------------------------------------+
// | axi_stream_header_arbiter: round-robin share of one header-insert block  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module axi_stream_header_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_REQ      = 4,
  parameter int REQ_WD       = $clog2(NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    hdr_valid,
  input  logic [NUM_REQ*DATA_WD-1:0]            hdr_data,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0]       hdr_keep,
  input  logic [NUM_REQ*(BYTE_CNT_WD+1)-1:0]    hdr_byte_cnt,
  output logic [NUM_REQ-1:0]                    hdr_ready,
  input  logic [NUM_REQ-1:0]                    pld_valid,
  input  logic [NUM_REQ*DATA_WD-1:0]            pld_data,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0]       pld_keep,
  input  logic [NUM_REQ-1:0]                    pld_last,
  output logic [NUM_REQ-1:0]                    pld_ready,
  output logic                                  valid_in,
  output logic [DATA_WD-1:0]                    data_in,
  output logic [DATA_BYTE_WD-1:0]               keep_in,
  output logic                                  last_in,
  input  logic                                  ready_in,
  output logic                                  valid_insert,
  output logic [DATA_WD-1:0]                    data_insert,
  output logic [DATA_BYTE_WD-1:0]               keep_insert,
  output logic [BYTE_CNT_WD:0]                  byte_insert_cnt,
  input  logic                                  ready_insert,
  output logic                                  busy,
  output logic [REQ_WD-1:0]                     grant_id,
  output logic                                  err_order
);

  localparam int CNT_WD = BYTE_CNT_WD + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [REQ_WD-1:0]       last_grant_q, last_grant_d;
  logic [REQ_WD-1:0]       grant_id_q, grant_id_d;
  logic                    hdr_pend_q, hdr_pend_d;
  logic                    err_order_q, err_order_d;
  logic [DATA_WD-1:0]      data_insert_q, data_insert_d;
  logic [DATA_BYTE_WD-1:0] keep_insert_q, keep_insert_d;
  logic [CNT_WD-1:0]       byte_cnt_q, byte_cnt_d;

  logic                    win_found;
  logic [REQ_WD-1:0]       win_idx;

  // Search starts just past the previous winner so every source gets a turn.
  always_comb begin : win_search
    int t;
    win_found = 1'b0;
    win_idx   = '0;
    t         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      t = int'(last_grant_q) + k;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      if (!win_found && hdr_valid[REQ_WD'(t)]) begin
        win_found = 1'b1;
        win_idx   = REQ_WD'(t);
      end
    end
  end

  always_comb begin
    hdr_ready = '0;
    pld_ready = '0;
    valid_in  = 1'b0;
    data_in   = '0;
    keep_in   = '0;
    last_in   = 1'b0;
    if (rst_n && state_q == S_IDLE && win_found) begin
      hdr_ready[win_idx] = 1'b1;
    end
    if (state_q == S_XFER) begin
      valid_in              = pld_valid[grant_id_q];
      data_in               = pld_data[grant_id_q*DATA_WD +: DATA_WD];
      keep_in               = pld_keep[grant_id_q*DATA_BYTE_WD +: DATA_BYTE_WD];
      last_in               = pld_last[grant_id_q];
      pld_ready[grant_id_q] = ready_in;
    end
  end

  assign valid_insert    = hdr_pend_q;
  assign data_insert     = data_insert_q;
  assign keep_insert     = keep_insert_q;
  assign byte_insert_cnt = byte_cnt_q;
  assign busy            = (state_q == S_XFER);
  assign grant_id        = grant_id_q;
  assign err_order       = err_order_q;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    hdr_pend_d    = hdr_pend_q;
    err_order_d   = err_order_q;
    data_insert_d = data_insert_q;
    keep_insert_d = keep_insert_q;
    byte_cnt_d    = byte_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d       = S_XFER;
          data_insert_d = hdr_data[win_idx*DATA_WD +: DATA_WD];
          keep_insert_d = hdr_keep[win_idx*DATA_BYTE_WD +: DATA_BYTE_WD];
          byte_cnt_d    = hdr_byte_cnt[win_idx*CNT_WD +: CNT_WD];
          hdr_pend_d    = 1'b1;
          grant_id_d    = win_idx;
          last_grant_d  = win_idx;
        end
      end
      S_XFER: begin
        if (hdr_pend_q && ready_insert) hdr_pend_d = 1'b0;
        if (valid_in && ready_in && last_in) begin
          state_d = S_IDLE;
          // Payload finished while its header was still outstanding.
          if (hdr_pend_q && !ready_insert) err_order_d = 1'b1;
          hdr_pend_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_grant_q  <= REQ_WD'(NUM_REQ - 1);
      grant_id_q    <= '0;
      hdr_pend_q    <= 1'b0;
      err_order_q   <= 1'b0;
      data_insert_q <= '0;
      keep_insert_q <= '0;
      byte_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      hdr_pend_q    <= hdr_pend_d;
      err_order_q   <= err_order_d;
      data_insert_q <= data_insert_d;
      keep_insert_q <= keep_insert_d;
      byte_cnt_q    <= byte_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_header_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_axi_stream_header_arbiter: directed self-checking bench               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_axi_stream_header_arbiter;

  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 3;
  localparam int N  = 4;
  localparam int RW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    hdr_valid;
  logic [N*DW-1:0] hdr_data;
  logic [N*BW-1:0] hdr_keep;
  logic [N*CW-1:0] hdr_byte_cnt;
  logic [N-1:0]    hdr_ready;
  logic [N-1:0]    pld_valid;
  logic [N*DW-1:0] pld_data;
  logic [N*BW-1:0] pld_keep;
  logic [N-1:0]    pld_last;
  logic [N-1:0]    pld_ready;
  logic            valid_in;
  logic [DW-1:0]   data_in;
  logic [BW-1:0]   keep_in;
  logic            last_in;
  logic            ready_in;
  logic            valid_insert;
  logic [DW-1:0]   data_insert;
  logic [BW-1:0]   keep_insert;
  logic [CW-1:0]   byte_insert_cnt;
  logic            ready_insert;
  logic            busy;
  logic [RW-1:0]   grant_id;
  logic            err_order;

  int checks   = 0;
  int failures = 0;

  axi_stream_header_arbiter #(.DATA_WD(DW), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_valid(hdr_valid), .hdr_data(hdr_data), .hdr_keep(hdr_keep),
    .hdr_byte_cnt(hdr_byte_cnt), .hdr_ready(hdr_ready),
    .pld_valid(pld_valid), .pld_data(pld_data), .pld_keep(pld_keep),
    .pld_last(pld_last), .pld_ready(pld_ready),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in),
    .last_in(last_in), .ready_in(ready_in),
    .valid_insert(valid_insert), .data_insert(data_insert),
    .keep_insert(keep_insert), .byte_insert_cnt(byte_insert_cnt),
    .ready_insert(ready_insert),
    .busy(busy), .grant_id(grant_id), .err_order(err_order)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] hv(input int g);
    return 32'hA000_0000 + 32'(g);
  endfunction

  function automatic logic [DW-1:0] bv(input int g, input int b);
    return 32'hB000_0000 + 32'(g << 8) + 32'(b);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic beat(input int g, input int b, input bit last);
    pld_valid[g]         = 1'b1;
    pld_data[g*DW +: DW] = bv(g, b);
    pld_keep[g*BW +: BW] = last ? 4'h3 : 4'hF;
    pld_last[g]          = last;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #20;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; hdr_valid = '0; pld_valid = '0; pld_last = '0;
    pld_data = '0; pld_keep = '0; ready_in = 1'b0; ready_insert = 1'b0;
    for (int g = 0; g < N; g++) begin
      hdr_data[g*DW +: DW]       = hv(g);
      hdr_keep[g*BW +: BW]       = 4'(4'hF ^ g);
      hdr_byte_cnt[g*CW +: CW]   = 3'(g + 1);
    end
    do_reset();

    // Reset state
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_valid_insert", valid_insert, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_err", err_order, 0);
    chk("rst_data_insert", data_insert, 0);
    chk("rst_valid_in", valid_in, 0);

    // Single source (2), four beats
    hdr_valid = 4'b0100; ready_in = 1'b1; ready_insert = 1'b1;
    settle();
    chk("t1_hdr_ready", hdr_ready, 4'b0100);
    chk("t1_idle_vins", valid_insert, 0);
    step();
    hdr_valid = '0;
    beat(2, 0, 1'b0);
    settle();
    chk("t1_hdr_ready_once", hdr_ready, 0);
    chk("t1_vins", valid_insert, 1);
    chk("t1_busy", busy, 1);
    chk("t1_grant", grant_id, 2);
    chk("t1_dins", data_insert, hv(2));
    chk("t1_kins", keep_insert, 4'hD);
    chk("t1_cnt", byte_insert_cnt, 3);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) beat(2, b, b == 3);
      settle();
      chk("t1_data_in", data_in, bv(2, b));
      chk("t1_last_in", last_in, (b == 3) ? 1 : 0);
      chk("t1_pld_ready", pld_ready, 4'b0100);
      step();
    end
    pld_valid = '0;
    settle();
    chk("t1_end_busy", busy, 0);
    chk("t1_end_valid_in", valid_in, 0);
    chk("t1_end_vins", valid_insert, 0);

    // Round-robin, all sources valid, 3-beat packets
    do_reset();
    hdr_valid = 4'hF; ready_in = 1'b1; ready_insert = 1'b1;
    pld_valid = '1; pld_last = '1;
    for (int g = 0; g < N; g++) pld_data[g*DW +: DW] = 32'hDEAD_0000 + 32'(g);
    for (int p = 0; p < 6; p++) begin
      int g;
      g = p % N;
      settle();
      chk("t2_gap_busy", busy, 0);
      chk("t2_hdr_ready", hdr_ready, 64'(1) << g);
      chk("t2_gap_pld_ready", pld_ready, 0);
      step();
      for (int b = 0; b < 3; b++) begin
        beat(g, b, b == 2);
        settle();
        chk("t2_grant", grant_id, 64'(g));
        chk("t2_busy", busy, 1);
        chk("t2_vins", valid_insert, (b == 0) ? 1 : 0);
        chk("t2_data_in", data_in, bv(g, b));
        chk("t2_keep_in", keep_in, (b == 2) ? 4'h3 : 4'hF);
        chk("t2_pld_ready", pld_ready, 64'(1) << g);
        step();
      end
    end

    // Backpressure on both channels, source 3
    pld_valid = '0; pld_last = '0;
    hdr_valid = 4'b1000;
    settle();
    chk("t3_hdr_ready", hdr_ready, 4'b1000);
    step();
    hdr_valid = '0; ready_insert = 1'b0;
    for (int c = 0; c < 3; c++) begin
      beat(3, c, 1'b0);
      settle();
      chk("t3_vins_hold", valid_insert, 1);
      chk("t3_dins_hold", data_insert, hv(3));
      chk("t3_data_in", data_in, bv(3, c));
      step();
    end
    ready_insert = 1'b1; ready_in = 1'b0;
    beat(3, 3, 1'b0);
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("t3_valid_in_hold", valid_in, 1);
      chk("t3_data_in_hold", data_in, bv(3, 3));
      chk("t3_pld_ready_low", pld_ready, 0);
      chk("t3_grant_hold", grant_id, 3);
      chk("t3_vins", valid_insert, (c == 0) ? 1 : 0);
      step();
    end
    ready_in = 1'b1;
    settle();
    chk("t3_release", pld_ready, 4'b1000);
    step();
    beat(3, 4, 1'b1);
    settle();
    chk("t3_last_data", data_in, bv(3, 4));
    chk("t3_last_busy", busy, 1);
    step();
    pld_valid = '0;
    settle();
    chk("t3_end_busy", busy, 0);
    chk("t3_end_err", err_order, 0);

    // Same-cycle header and single last beat, source 0
    hdr_valid = 4'b0001; ready_in = 1'b0; ready_insert = 1'b0;
    settle();
    chk("t4_hdr_ready", hdr_ready, 4'b0001);
    step();
    hdr_valid = '0;
    beat(0, 0, 1'b1);
    settle();
    chk("t4_vins", valid_insert, 1);
    chk("t4_pld_ready_low", pld_ready, 0);
    step();
    chk("t4_hold_busy", busy, 1);
    ready_in = 1'b1; ready_insert = 1'b1;
    settle();
    chk("t4_pld_ready", pld_ready, 4'b0001);
    step();
    pld_valid = '0;
    settle();
    chk("t4_busy", busy, 0);
    chk("t4_err", err_order, 0);
    chk("t4_vins_done", valid_insert, 0);

    // Last beat before header accepted, source 1
    hdr_valid = 4'b0010; ready_insert = 1'b0; ready_in = 1'b1;
    settle();
    chk("t5_hdr_ready", hdr_ready, 4'b0010);
    step();
    hdr_valid = '0;
    beat(1, 0, 1'b1);
    settle();
    chk("t5_vins", valid_insert, 1);
    chk("t5_last_in", last_in, 1);
    step();
    pld_valid = '0;
    settle();
    chk("t5_err", err_order, 1);
    chk("t5_vins_drop", valid_insert, 0);
    chk("t5_idle", busy, 0);
    step();
    chk("t5_err_sticky", err_order, 1);

    // Reset mid-packet, source 1
    hdr_valid = 4'b0010; ready_insert = 1'b1; ready_in = 1'b1;
    settle();
    chk("t6_hdr_ready", hdr_ready, 4'b0010);
    step();
    hdr_valid = '0;
    beat(1, 0, 1'b0);
    step();
    beat(1, 1, 1'b0);
    step();
    beat(1, 2, 1'b0);
    settle();
    chk("t6_data_in", data_in, bv(1, 2));
    chk("t6_grant", grant_id, 1);
    hdr_valid = 4'b0011;
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_grant", grant_id, 0);
    chk("t6_rst_err", err_order, 0);
    chk("t6_rst_dins", data_insert, 0);
    chk("t6_rst_cnt", byte_insert_cnt, 0);
    chk("t6_rst_valid_in", valid_in, 0);
    chk("t6_rst_pld_ready", pld_ready, 0);
    chk("t6_rst_hdr_ready", hdr_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pld_valid = '0;
    settle();
    chk("t6_first_win", hdr_ready, 4'b0001);
    step();
    chk("t6_grant0", grant_id, 0);
    chk("t6_busy", busy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
